div_seq_ctrl: RTL and testbench
===============================

# div_seq_ctrl

Sequential divide controller for the N-bit divider datapath. It accepts one dividend/divisor pair over a valid/ready handshake and runs one restoring subtract-and-select step per clock, most significant quotient bit first. It returns quotient and remainder over a second valid/ready handshake. This is the area-minimal alternative to the fully unrolled pipelined divider: one step instance shared across DIVIDENDLEN cycles.

## Interface
- DIVIDENDLEN, 16, dividend and quotient width
- DIVISORLEN, 8, divisor and remainder width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  controller can accept; high only in IDLE
- dividend  in  DIVIDENDLEN  unsigned dividend
- divisor  in  DIVISORLEN  unsigned divisor
- out_valid  out  1  result present; high only in DONE
- out_ready  in  1  consumer takes result
- quotient  out  DIVIDENDLEN  unsigned quotient
- remainder  out  DIVISORLEN  unsigned remainder, always < divisor when divisor != 0
- div_by_zero  out  1  divisor was 0 (only driven with DIV_ZERO_CHECK_EN; otherwise tied 0)

## Operation
- States: IDLE, RUN, DONE. Reset value is IDLE.
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, step counter=0.
- IDLE: on in_valid && in_ready, latch the inputs.
  - Q <= dividend, R <= 0 (DIVISORLEN+1 bits), D <= divisor, count <= DIVIDENDLEN-1.
  - Next state is RUN.
- RUN, one step per cycle:
  - t = {R[DIVISORLEN-1:0], Q[DIVIDENDLEN-1]} (DIVISORLEN+1 bits).
  - If t >= {1'b0,D}: R <= t - D and qbit = 1. Else R <= t and qbit = 0.
  - Q <= {Q[DIVIDENDLEN-2:0], qbit}.
  - If count == 0, go to DONE. Else decrement count.
- DONE:
  - quotient = Q and remainder = R[DIVISORLEN-1:0].
  - Outputs are held stable while out_ready is low.
  - On out_valid && out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. No new operand is accepted in the same cycle a result is taken.
- Inputs are sampled only at the accept edge. Changes during RUN have no effect.
- Divisor 0 without the macro: the normal algorithm runs, giving quotient = all ones and remainder = dividend[DIVISORLEN-1:0].
- Reset asserted in any state, including mid-RUN, aborts the operation and restores the reset values on the next edge. No partial result is emitted.

## Timing
- Accept at edge e. RUN occupies edges e+1 .. e+DIVIDENDLEN. out_valid rises after edge e+DIVIDENDLEN.
- Accept-to-out_valid latency is DIVIDENDLEN+1 cycles, which is 17 at the defaults.
- Minimum issue interval is DIVIDENDLEN+2 cycles: IDLE, RUN×N, DONE.
- out_valid/in_ready are registered state decodes. Neither has a combinational path from in_valid or out_ready.

## Configuration
- DIV_ZERO_CHECK_EN defined:
  - An accept with divisor == 0 goes straight from IDLE to DONE.
  - Outputs: quotient = all ones, remainder = dividend[DIVISORLEN-1:0], div_by_zero = 1.
  - out_valid rises one cycle after accept.
  - div_by_zero clears on the handshake that leaves DONE.
- Undefined: no zero check, full DIVIDENDLEN-cycle run for every divisor, and div_by_zero is constant 0.

## Structure
- Shared package div_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a packed struct for the operand pair {dividend, divisor};
  - a packed struct for the result {quotient, remainder, div_by_zero};
  - width localparams derived from DIVIDENDLEN/DIVISORLEN.
- One combinational sub-module, div_step, computes the single restoring step.
  - Inputs: R, the incoming dividend bit, D.
  - Outputs: next R, qbit.
- The FSM, counter and Q/R/D registers live in div_seq_ctrl.

## Test plan
- 1000/7, out_ready=1 → out_valid exactly 17 cycles after accept, quotient=142, remainder=6.
- 65535/255 → quotient=257, remainder=0.
- 5/200 → quotient=0, remainder=5. Hold out_ready=0 for 10 cycles: outputs and out_valid stay stable, and in_ready stays 0 throughout.
- 1234/0:
  - Without macro → after 17 cycles, quotient=0xFFFF, remainder=210, div_by_zero=0.
  - With DIV_ZERO_CHECK_EN → after 1 cycle, same values with div_by_zero=1.
- Accept 1000/7, assert reset at RUN cycle 5, then release → next cycle in_ready=1, out_valid=0, quotient=0. Then accept 100/9 → quotient=11, remainder=1.
- Back-to-back operations with in_valid held high → accept only in IDLE, interval 18 cycles, with each result matching its own operands.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and widths for the sequential restoring divider.
package div_pkg;
    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W = 8;
    localparam int REM_W = DIVISOR_W + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef struct packed {
        logic [DIVIDEND_W-1:0] dividend;
        logic [DIVISOR_W-1:0] divisor;
    } operand_t;
    typedef struct packed {
        logic [DIVIDEND_W-1:0] quotient;
        logic [DIVISOR_W-1:0] remainder;
        logic div_by_zero;
    } result_t;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring subtract-and-select step of the divider.
module div_step #(
    parameter int DIVISORLEN = div_pkg::DIVISOR_W
) (
    input  logic [DIVISORLEN-1:0] r,
    input  logic                  din,
    input  logic [DIVISORLEN-1:0] d,
    output logic [DIVISORLEN-1:0] r_next,
    output logic                  qbit
);
    logic [DIVISORLEN:0] t;
    assign t = {r, din};
    assign qbit = t >= {1'b0, d};
    // The difference is always below d, so it fits the narrow remainder.
    assign r_next = qbit ? DIVISORLEN'(t - {1'b0, d}) : DIVISORLEN'(t);
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: iterative divider, one quotient bit per clock, valid/ready on both sides.
// Optional DIV_ZERO_CHECK_EN short-circuits a zero divisor straight to DONE with div_by_zero set.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int DIVIDENDLEN = DIVIDEND_W,
    parameter int DIVISORLEN = DIVISOR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIVIDENDLEN-1:0] dividend,
    input  logic [DIVISORLEN-1:0]  divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIVIDENDLEN-1:0] quotient,
    output logic [DIVISORLEN-1:0]  remainder,
    output logic                   div_by_zero
);
    localparam int CW = cnt_w(DIVIDENDLEN);
    state_t state;
    logic [DIVIDENDLEN-1:0] q;
    logic [DIVISORLEN-1:0] r, d, r_next;
    logic [CW-1:0] count;
    logic qbit;
    div_step #(.DIVISORLEN(DIVISORLEN)) u_step (
        .r(r),
        .din(q[DIVIDENDLEN-1]),
        .d(d),
        .r_next(r_next),
        .qbit(qbit)
    );
    assign quotient = q;
    assign remainder = r;
`ifndef DIV_ZERO_CHECK_EN
    assign div_by_zero = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            q <= '0;
            r <= '0;
            d <= '0;
            count <= '0;
`ifdef DIV_ZERO_CHECK_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
                    if (divisor == '0) begin
                        q <= '1;
                        r <= dividend[DIVISORLEN-1:0];
                        div_by_zero <= 1'b1;
                        out_valid <= 1'b1;
                        state <= DONE;
                    end else
`endif
                    begin
                        q <= dividend;
                        r <= '0;
                        d <= divisor;
                        count <= CW'(DIVIDENDLEN - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    q <= {q[DIVIDENDLEN-2:0], qbit};
                    r <= r_next;
                    if (count == '0) begin
                        state <= DONE;
                        out_valid <= 1'b1;
                    end else count <= count - 1'b1;
                end
                DONE: if (out_ready) begin
                    state <= IDLE;
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                    div_by_zero <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed-vector bench for div_seq_ctrl at default widths.
module tb_div_seq_ctrl;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [15:0] dividend = '0, quotient;
    logic [7:0] divisor = '0, remainder;
    logic in_ready, out_valid, div_by_zero;
    int checks = 0, failures = 0, cyc = 0;
    div_seq_ctrl dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    // Inputs are scrambled after the accept edge; the result must reflect only the latched pair.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                          input logic [7:0] er, input int elat, input logic edz, input int hold);
        int n = 0;
        out_ready = (hold == 0);
        dividend = a;
        divisor = b;
        in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        do begin
            tick();
            n++;
            in_valid = 1'b0;
            dividend = ~a;
            divisor = 8'd3;
        end while (!out_valid && n < 40);
        check("latency", n, elat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edz);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_quotient", quotient, eq);
            check("hold_remainder", remainder, er);
        end
        out_ready = 1'b1;
        tick();
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_dbz", div_by_zero, 0);
    endtask
    logic [15:0] bb_a [3] = '{16'd50000, 16'd300, 16'd4321};
    logic [7:0] bb_b [3] = '{8'd123, 8'd1, 8'd17};
    logic [15:0] bb_q [3] = '{16'd406, 16'd300, 16'd254};
    logic [7:0] bb_r [3] = '{8'd62, 8'd0, 8'd3};
    int acc [3];
    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        run_op(16'd1000, 8'd7, 16'd142, 8'd6, 17, 1'b0, 0);
        run_op(16'd65535, 8'd255, 16'd257, 8'd0, 17, 1'b0, 0);
        run_op(16'd5, 8'd200, 16'd0, 8'd5, 17, 1'b0, 10);
`ifdef DIV_ZERO_CHECK_EN
        run_op(16'd1234, 8'd0, 16'hFFFF, 8'd210, 1, 1'b1, 0);
`else
        run_op(16'd1234, 8'd0, 16'hFFFF, 8'd210, 17, 1'b0, 0);
`endif
        // Abort mid-run: the reset edge lands on the fifth RUN step.
        dividend = 16'd1000;
        divisor = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("mid_run_busy", in_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_quotient", quotient, 0);
        run_op(16'd100, 8'd9, 16'd11, 8'd1, 17, 1'b0, 0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int t = 0;
            dividend = bb_a[k];
            divisor = bb_b[k];
            while (!in_ready && t < 40) begin
                tick();
                t++;
            end
            check("b2b_accept", in_ready, 1);
            acc[k] = cyc;
            tick();
            t = 0;
            while (!out_valid && t < 40) begin
                check("b2b_busy", in_ready, 0);
                tick();
                t++;
            end
            check("b2b_valid", out_valid, 1);
            check("b2b_quotient", quotient, bb_q[k]);
            check("b2b_remainder", remainder, bb_r[k]);
            if (k > 0) check("b2b_interval", acc[k] - acc[k-1], 18);
        end
        in_valid = 1'b0;
        tick();
        check("final_idle", in_ready, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
